regbank_port_ctrl: RTL and testbench

- Initiator side of the 16-entry register bank interface.
- Accepts operand-fetch requests from decode and sequences the bank read strobe (RE, registered read data one edge later), so that fetched operands reach execute through a valid/ready handshake.
- Queues execute write-backs and drives RD/WB/WE for the bank's negedge write.
- Keeps a pending-write scoreboard for RAW/WAW stalls, and owns the PC value that the bank overwrites into entry 15 on every negedge.

---
 rtl/regbank_port_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_regbank_port_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_port_ctrl.sv
// Initiator-side controller for a 16-entry register bank: sequences operand reads,
// queues write-backs, tracks pending writers for RAW/WAW stalls and owns the PC.
module regbank_port_ctrl #(
    parameter int unsigned    BUS      = 32,
    parameter int unsigned    DIR      = 4,
    parameter int unsigned    WB_DEPTH = 4,
    parameter logic [BUS-1:0] PC_RESET = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    // decode-side fetch request
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DIR-1:0] in_rs,
    input  logic [DIR-1:0] in_rx,
    input  logic [DIR-1:0] in_rk,
    input  logic [DIR-1:0] in_rd,
    input  logic           in_wr,
    // execute-side operands
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BUS-1:0] out_rsd,
    output logic [BUS-1:0] out_rxd,
    output logic [BUS-1:0] out_rkd,
    // execute write-back
    input  logic           wb_valid,
    output logic           wb_ready,
    input  logic [DIR-1:0] wb_rd,
    input  logic [BUS-1:0] wb_data,
    // program counter
    input  logic           pc_we,
    input  logic [BUS-1:0] pc_next,
    output logic [BUS-1:0] pc_cur,
    // register bank
    output logic [DIR-1:0] RS,
    output logic [DIR-1:0] RX,
    output logic [DIR-1:0] RK,
    output logic [DIR-1:0] RD,
    output logic [BUS-1:0] WB,
    output logic [BUS-1:0] PCi,
    output logic           WE,
    output logic           RE,
    input  logic [BUS-1:0] RSd,
    input  logic [BUS-1:0] RXd,
    input  logic [BUS-1:0] RKd,
    input  logic [BUS-1:0] PCo
);

    localparam int unsigned NREG   = 1 << DIR;
    localparam int unsigned PC_IDX = NREG - 1;
    localparam int unsigned PTR_W  = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [DIR-1:0] rd;
        logic [BUS-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic [BUS-1:0] rsd;
        logic [BUS-1:0] rxd;
        logic [BUS-1:0] rkd;
    } operands_t;

    logic             capture;
    logic [2:0]       reads_used;
    logic             hazard;
    logic             accept;
    logic             out_pop;
    operands_t        bank_ops;
    operands_t        head;
    operands_t        skid;
    logic             skid_valid;
    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_set;
    logic [NREG-1:0]  pending_clr;
    wb_entry_t        fifo_mem [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wb_count;
    logic [CNT_W-1:0] wb_count_next;
    logic             wb_push;
    logic             wb_pop;
    wb_entry_t        wb_head;
    logic             head_is_pc;

    // Two read credits shared by the RE stage, the capture stage and the skid buffer.
    assign reads_used = 3'(RE) + 3'(capture) + 3'(out_valid) + 3'(skid_valid);
    assign hazard     = pending[in_rs] | pending[in_rx] | pending[in_rk] | (in_wr & pending[in_rd]);
    assign in_ready   = (reads_used < 3'd2) && !hazard;
    assign accept     = in_valid && in_ready;
    assign out_pop    = out_valid && out_ready;
    assign bank_ops   = '{rsd: RSd, rxd: RXd, rkd: RKd};

    assign out_rsd = head.rsd;
    assign out_rxd = head.rxd;
    assign out_rkd = head.rkd;
    assign pc_cur  = PCo;

    // Read issue: latch indices and strobe RE once per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RE      <= 1'b0;
            RS      <= '0;
            RX      <= '0;
            RK      <= '0;
            capture <= 1'b0;
        end else begin
            RE      <= accept;
            capture <= RE;
            if (accept) begin
                RS <= in_rs;
                RX <= in_rx;
                RK <= in_rk;
            end
        end
    end

    // Two-entry output skid buffer; head drives the operand outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (out_pop) begin
            if (skid_valid) begin
                head <= skid;
                if (capture) begin
                    skid <= bank_ops;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (capture) begin
                head <= bank_ops;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (capture) begin
            if (!out_valid) begin
                head      <= bank_ops;
                out_valid <= 1'b1;
            end else begin
                skid       <= bank_ops;
                skid_valid <= 1'b1;
            end
        end
    end

    // Write-back FIFO; the head is drained every cycle it is non-empty.
    assign wb_ready   = (wb_count != CNT_W'(WB_DEPTH));
    assign wb_push    = wb_valid && wb_ready;
    assign wb_pop     = (wb_count != '0);
    assign wb_head    = fifo_mem[rd_ptr];
    assign head_is_pc = (wb_head.rd == DIR'(PC_IDX));

    always_comb begin
        wb_count_next = wb_count;
        if (wb_push && !wb_pop) begin
            wb_count_next = wb_count + CNT_W'(1);
        end else if (!wb_push && wb_pop) begin
            wb_count_next = wb_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wb_push) begin
            fifo_mem[wr_ptr] <= '{rd: wb_rd, data: wb_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wb_count <= '0;
        end else begin
            wb_count <= wb_count_next;
            if (wb_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (wb_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Bank write port: PC-targeted write-backs never reach the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE <= 1'b0;
            RD <= '0;
            WB <= '0;
        end else begin
            WE <= wb_pop && !head_is_pc;
            if (wb_pop && !head_is_pc) begin
                RD <= wb_head.rd;
                WB <= wb_head.data;
            end
        end
    end

    // Scoreboard: a new writer set on the same edge as a retiring write wins.
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (accept && in_wr && (in_rd != DIR'(PC_IDX))) begin
            pending_set = NREG'(1) << in_rd;
        end
        if (wb_pop) begin
            pending_clr = NREG'(1) << wb_head.rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pending_clr) | pending_set;
        end
    end

    // PC register, rewritten into bank entry 15 every negedge through PCi.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCi <= PC_RESET;
        end else if (pc_we) begin
            PCi <= pc_next;
        end else if (wb_pop && head_is_pc) begin
            PCi <= wb_head.data;
        end
    end

    // A captured read must always find a free slot in the skid buffer.
    assert property (@(posedge clk) disable iff (!rst_n)
        (capture && !out_pop) |-> !(out_valid && skid_valid));

    assert property (@(posedge clk) disable iff (!rst_n)
        WE |-> (RD != DIR'(PC_IDX)));

endmodule

// File: tb/tb_regbank_port_ctrl.sv
// Bench for regbank_port_ctrl: a behavioural register bank plus directed scenarios
// and a randomized run checked against a queue-based model of the interface.
module tb_regbank_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs, in_rx, in_rk, in_rd;
    logic        in_wr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rsd, out_rxd, out_rkd;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_we;
    logic [31:0] pc_next;
    logic [31:0] pc_cur;
    logic [3:0]  RS, RX, RK, RD;
    logic [31:0] WB, PCi;
    logic        WE, RE;
    logic [31:0] RSd, RXd, RKd, PCo;

    int checks = 0;
    int errors = 0;

    regbank_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rx(in_rx), .in_rk(in_rk), .in_rd(in_rd), .in_wr(in_wr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rsd(out_rsd), .out_rxd(out_rxd), .out_rkd(out_rkd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_we(pc_we), .pc_next(pc_next), .pc_cur(pc_cur),
        .RS(RS), .RX(RX), .RK(RK), .RD(RD), .WB(WB), .PCi(PCi), .WE(WE), .RE(RE),
        .RSd(RSd), .RXd(RXd), .RKd(RKd), .PCo(PCo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: writes and PC overwrite at negedge, registered reads at posedge.
    logic [31:0] bank_regs [16];
    always @(negedge clk) begin
        if (WE) bank_regs[RD] = WB;
        bank_regs[15] = PCi;
    end
    always @(posedge clk) begin
        if (RE) begin
            RSd <= bank_regs[RS];
            RXd <= bank_regs[RX];
            RKd <= bank_regs[RK];
        end
        PCo <= bank_regs[15];
    end

    task automatic idle(input int n);
        in_valid = 0; in_wr = 0; wb_valid = 0; pc_we = 0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic preload(input logic [3:0] r, input logic [31:0] d);
        wb_valid = 1; wb_rd = r; wb_data = d;
        @(negedge clk);
        wb_valid = 0;
    endtask

    task automatic request(input logic [3:0] rs, input logic [3:0] rx, input logic [3:0] rk,
                           input logic wr, input logic [3:0] rd);
        in_valid = 1; in_rs = rs; in_rx = rx; in_rk = rk; in_wr = wr; in_rd = rd;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (RE !== 1'b0 || WE !== 1'b0) begin errors++; $display("FAIL reset_strobes: RE=%b WE=%b want 0 0", RE, WE); end
        checks++; if (out_valid !== 1'b0 || out_rsd !== 32'h0) begin errors++; $display("FAIL reset_out: valid=%b rsd=%h want 0 0", out_valid, out_rsd); end
        checks++; if (PCi !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", PCi); end
        checks++; if (RS !== 4'h0 || RD !== 4'h0 || WB !== 32'h0) begin errors++; $display("FAIL reset_bus: RS=%h RD=%h WB=%h want 0", RS, RD, WB); end
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: in=%b wb=%b want 1 1", in_ready, wb_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        for (int i = 0; i < 8; i++) preload(4'(i), 32'h11 * i);
        idle(3);
        out_ready = 1;
        request(4'd1, 4'd2, 4'd3, 1'b0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        checks++; if (RE !== 1'b1 || RS !== 4'd1 || RX !== 4'd2 || RK !== 4'd3) begin errors++; $display("FAIL basic_re: RE=%b RS=%h RX=%h RK=%h want 1 1 2 3", RE, RS, RX, RK); end
        @(negedge clk);
        checks++; if (RE !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_e1: RE=%b out_valid=%b want 0 0", RE, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_rsd !== 32'h11 || out_rxd !== 32'h22 || out_rkd !== 32'h33)
            begin errors++; $display("FAIL basic_data: valid=%b %h %h %h want 1 11 22 33", out_valid, out_rsd, out_rxd, out_rkd); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_ir;
        logic [95:0] exp_d [4];
        int nacc, ncons;
        logic acc;
        exp_ir = 4'b0011;
        for (int k = 0; k < 4; k++) exp_d[k] = {32'h11 * (k + 1), 32'h11 * (k + 2), 32'h11 * (k + 3)};
        out_ready = 0; nacc = 0; ncons = 0;
        for (int c = 0; c < 4; c++) begin
            request(4'(nacc + 1), 4'(nacc + 2), 4'(nacc + 3), 1'b0, 4'd0);
            #1;
            acc = in_ready;
            checks++; if (in_ready !== exp_ir[c]) begin errors++; $display("FAIL b2b_credit c%0d: in_ready=%b want %b", c, in_ready, exp_ir[c]); end
            @(negedge clk);
            if (acc) nacc++;
        end
        checks++; if (nacc != 2) begin errors++; $display("FAIL b2b_count: accepted %0d want 2", nacc); end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rsd !== 32'h11)
                begin errors++; $display("FAIL b2b_hold c%0d: in_ready=%b valid=%b rsd=%h want 0 1 11", c, in_ready, out_valid, out_rsd); end
            @(negedge clk);
        end
        out_ready = 1;
        for (int c = 0; c < 30 && (ncons < 4 || nacc < 4); c++) begin
            if (out_valid) begin
                checks++; if ({out_rsd, out_rxd, out_rkd} !== exp_d[ncons])
                    begin errors++; $display("FAIL b2b_order %0d: got %h want %h", ncons, {out_rsd, out_rxd, out_rkd}, exp_d[ncons]); end
                ncons++;
            end
            if (nacc < 4) request(4'(nacc + 1), 4'(nacc + 2), 4'(nacc + 3), 1'b0, 4'd0);
            else in_valid = 0;
            #1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) nacc++;
        end
        in_valid = 0;
        checks++; if (ncons != 4 || nacc != 4) begin errors++; $display("FAIL b2b_drain: consumed %0d accepted %0d want 4 4", ncons, nacc); end
        idle(2);
    endtask

    task automatic test_hazard();
        bit seen;
        out_ready = 1;
        request(4'd0, 4'd0, 4'd0, 1'b1, 4'd5);
        @(negedge clk);
        request(4'd5, 4'd1, 4'd2, 1'b0, 4'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall c%0d: in_ready=%b want 0", c, in_ready); end
            @(negedge clk);
        end
        wb_valid = 1; wb_rd = 4'd5; wb_data = 32'hABCD;
        @(negedge clk);
        wb_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b0 || WE !== 1'b0) begin errors++; $display("FAIL hazard_queued: in_ready=%b WE=%b want 0 0", in_ready, WE); end
        @(negedge clk);
        #1;
        checks++; if (WE !== 1'b1 || RD !== 4'd5 || WB !== 32'hABCD) begin errors++; $display("FAIL hazard_we: WE=%b RD=%h WB=%h want 1 5 abcd", WE, RD, WB); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        checks++; if (WE !== 1'b0) begin errors++; $display("FAIL hazard_we_pulse: WE=%b want 0", WE); end
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen || out_rsd !== 32'hABCD || out_rxd !== 32'h11 || out_rkd !== 32'h22)
            begin errors++; $display("FAIL hazard_data: seen=%0d %h %h %h want 1 abcd 11 22", seen, out_rsd, out_rxd, out_rkd); end
        idle(2);
    endtask

    task automatic test_wb_stream();
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                wb_valid = 1; wb_rd = 4'(8 + i); wb_data = 32'h1000 + i;
                #1;
                checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wb_ready %0d: got %b want 1", i, wb_ready); end
            end else begin
                wb_valid = 0;
            end
            @(negedge clk);
            checks++; if (WE !== (i >= 1 && i <= 5)) begin errors++; $display("FAIL wb_we %0d: got %b want %b", i, WE, (i >= 1 && i <= 5)); end
            if (i >= 1 && i <= 5) begin
                checks++; if (RD !== 4'(7 + i) || WB !== 32'h0FFF + i)
                    begin errors++; $display("FAIL wb_order %0d: RD=%h WB=%h want %h %h", i, RD, WB, 4'(7 + i), 32'h0FFF + i); end
            end
        end
    endtask

    task automatic test_pc();
        wb_valid = 1; wb_rd = 4'd15; wb_data = 32'h100;
        @(negedge clk);
        wb_valid = 0;
        checks++; if (WE !== 1'b0 || PCi !== 32'h0) begin errors++; $display("FAIL pc_pre: WE=%b PCi=%h want 0 0", WE, PCi); end
        @(negedge clk);
        checks++; if (WE !== 1'b0 || PCi !== 32'h100) begin errors++; $display("FAIL pc_wb: WE=%b PCi=%h want 0 100", WE, PCi); end
        checks++; if (pc_cur !== 32'h0) begin errors++; $display("FAIL pc_cur_old: got %h want 0", pc_cur); end
        @(negedge clk);
        checks++; if (pc_cur !== 32'h100) begin errors++; $display("FAIL pc_cur: got %h want 100", pc_cur); end
        wb_valid = 1; wb_rd = 4'd15; wb_data = 32'h300;
        @(negedge clk);
        wb_valid = 0; pc_we = 1; pc_next = 32'h200;
        @(negedge clk);
        pc_we = 0;
        checks++; if (PCi !== 32'h200 || WE !== 1'b0) begin errors++; $display("FAIL pc_priority: PCi=%h WE=%b want 200 0", PCi, WE); end
        @(negedge clk);
        checks++; if (PCi !== 32'h200) begin errors++; $display("FAIL pc_hold: PCi=%h want 200", PCi); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 0;
        request(4'd1, 4'd2, 4'd3, 1'b1, 4'd6);
        wb_valid = 1; wb_rd = 4'd9; wb_data = 32'h9999;
        @(negedge clk);
        in_valid = 0; wb_valid = 0;
        rst_n = 0;
        #1;
        checks++; if (RE !== 1'b0 || WE !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_strobes: RE=%b WE=%b valid=%b want 0 0 0", RE, WE, out_valid); end
        checks++; if (PCi !== 32'h0 || RS !== 4'h0) begin errors++; $display("FAIL rmid_pc: PCi=%h RS=%h want 0 0", PCi, RS); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        request(4'd6, 4'd9, 4'd1, 1'b0, 4'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_scoreboard: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rmid_fifo c%0d: WE=%b want 0", c, WE); end
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen || out_rsd !== 32'h66 || out_rxd !== 32'h1001 || out_rkd !== 32'h11)
            begin errors++; $display("FAIL rmid_data: seen=%0d %h %h %h want 1 66 1001 11", seen, out_rsd, out_rxd, out_rkd); end
        idle(2);
    endtask

    typedef struct {
        logic [95:0] d;
        int          ready;
    } rd_item_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_item_t;

    task automatic test_random();
        logic [31:0] mregs [16];
        logic [15:0] mpend;
        rd_item_t    readq [$];
        wb_item_t    wbq [$];
        logic [3:0]  writers [$];
        wb_item_t    w;
        logic        exp_we, exp_ov, exp_ir, exp_wr, hz, acc, wacc, pop;
        logic [3:0]  exp_rd;
        logic [31:0] exp_wb;
        int          k;
        for (int i = 0; i < 15; i++) begin
            mregs[i] = $urandom;
            preload(4'(i), mregs[i]);
        end
        mregs[15] = 32'h0;
        idle(3);
        mpend = '0; exp_we = 0; exp_rd = '0; exp_wb = '0; k = 0;
        for (int n = 0; n < 400; n++) begin
            exp_ov = 0;
            if (readq.size() > 0) exp_ov = (readq[0].ready <= n);
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_valid n%0d: got %b want %b", n, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if ({out_rsd, out_rxd, out_rkd} !== readq[0].d)
                    begin errors++; $display("FAIL rnd_data n%0d: got %h want %h", n, {out_rsd, out_rxd, out_rkd}, readq[0].d); end
            end
            checks++; if (WE !== exp_we) begin errors++; $display("FAIL rnd_we n%0d: got %b want %b", n, WE, exp_we); end
            if (exp_we) begin
                checks++; if (RD !== exp_rd || WB !== exp_wb) begin errors++; $display("FAIL rnd_wr n%0d: RD=%h WB=%h want %h %h", n, RD, WB, exp_rd, exp_wb); end
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs = 4'($urandom_range(0, 15)); in_rx = 4'($urandom_range(0, 15));
            in_rk = 4'($urandom_range(0, 15)); in_rd = 4'($urandom_range(0, 15));
            in_wr = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid = 0;
            if (writers.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, writers.size() - 1);
                wb_valid = 1; wb_rd = writers[k]; wb_data = $urandom;
            end
            #1;
            hz = mpend[in_rs] | mpend[in_rx] | mpend[in_rk] | (in_wr & mpend[in_rd]);
            exp_ir = (readq.size() < 2) && !hz;
            exp_wr = (wbq.size() < 4);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready n%0d: got %b want %b", n, in_ready, exp_ir); end
            checks++; if (wb_ready !== exp_wr) begin errors++; $display("FAIL rnd_wb_ready n%0d: got %b want %b", n, wb_ready, exp_wr); end
            acc = in_valid && exp_ir;
            wacc = wb_valid && exp_wr;
            pop = exp_ov && out_ready;
            if (pop) void'(readq.pop_front());
            exp_we = 0;
            if (wbq.size() > 0) begin
                w = wbq.pop_front();
                exp_we = (w.rd != 4'd15); exp_rd = w.rd; exp_wb = w.data;
                mpend[w.rd] = 1'b0;
            end
            if (acc) begin
                readq.push_back('{d: {mregs[in_rs], mregs[in_rx], mregs[in_rk]}, ready: n + 3});
                if (in_wr && in_rd != 4'd15) begin
                    mpend[in_rd] = 1'b1;
                    writers.push_back(in_rd);
                end
            end
            if (wacc) begin
                mregs[wb_rd] = wb_data;
                wbq.push_back('{rd: wb_rd, data: wb_data});
                writers.delete(k);
            end
            @(negedge clk);
        end
        idle(4);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_wr = 0; in_rs = 0; in_rx = 0; in_rk = 0; in_rd = 0;
        out_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; pc_we = 0; pc_next = 0;
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_hazard();
        test_wb_stream();
        test_pc();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
